// File: rtl/riscv_trap_ctrl_pkg.sv
// riscv_trap_ctrl_pkg
//   Shared RISC-V machine-mode definitions. The CSR register file and the
//   trap controller both import this package.
//   Contents: the trap sequencer state encoding, the mstatus field
//   positions, the mtvec mode encodings and the M-mode privilege code.
package riscv_trap_ctrl_pkg;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP_WR  = 2'd1,
        ST_MRET_WR  = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // mtvec[1:0] mode encodings
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Machine privilege level code, as written to MPP
    localparam logic [1:0] PRIV_LVL_M = 2'b11;

endpackage

// File: rtl/riscv_trap_ctrl.sv
// riscv_trap_ctrl
//   Sequences trap entry and mret for the commit stage. An accepted
//   request takes one cycle of CSR writes (TRAP_WR or MRET_WR), followed
//   by a fetch redirect that is held until fetch accepts it.
//   Ports:
//     clk, rst                        clock, async active-high reset
//     trap_valid_i/cause_i/pc_i       trap request from commit
//     mret_valid_i                    mret request from commit
//     req_ready_o                     high in IDLE only
//     csr_*_read_data_i               current mstatus/mepc/mtvec
//     csr_*_write_data_o/_valid_o     dedicated mstatus/mepc/mcause writes
//     csr_gen_write_valid_i/_o        generic CSR write, passed through in IDLE
//     redirect_valid_o/pc_o/ready_i   fetch redirect handshake
//     busy_o                          pipeline stall while not IDLE
module riscv_trap_ctrl
    import riscv_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_valid_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  mret_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] csr_mstatus_read_data_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_read_data_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_read_data_i,
    output logic [DATA_WIDTH-1:0] csr_mstatus_write_data_o,
    output logic [DATA_WIDTH-1:0] csr_mepc_write_data_o,
    output logic [DATA_WIDTH-1:0] csr_mcause_write_data_o,
    output logic                  csr_mstatus_write_valid_o,
    output logic                  csr_mepc_write_valid_o,
    output logic                  csr_mcause_write_valid_o,
    input  logic                  csr_gen_write_valid_i,
    output logic                  csr_gen_write_valid_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    input  logic                  redirect_ready_i,
    output logic                  busy_o
);

    localparam int DW = DATA_WIDTH;

    trap_state_e   state_q, state_d;
    logic [DW-1:0] cause_q, cause_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] target_q, target_d;

    logic          in_idle, in_trap_wr, in_mret_wr, in_redirect;
    logic [DW-1:0] mtvec_base, vec_offset, trap_target;
    logic [DW-1:0] mstatus_trap, mstatus_mret;

    // The mepc and pc LSBs are always forced to zero, so those bits are never read.
    logic unused_lsbs;
    assign unused_lsbs = csr_mepc_read_data_i[0] ^ pc_q[0];

    assign in_idle     = (state_q == ST_IDLE);
    assign in_trap_wr  = (state_q == ST_TRAP_WR);
    assign in_mret_wr  = (state_q == ST_MRET_WR);
    assign in_redirect = (state_q == ST_REDIRECT);

    // Vectored mode applies to interrupts only. 4*cause[DW-2:0] mod 2^DW
    // equals cause[DW-3:0] shifted left by two.
    assign mtvec_base  = {csr_mtvec_read_data_i[DW-1:2], 2'b00};
    assign vec_offset  = {cause_q[DW-3:0], 2'b00};
    assign trap_target = ((csr_mtvec_read_data_i[1:0] == MTVEC_MODE_VECTORED) && cause_q[DW-1])
                         ? (mtvec_base + vec_offset) : mtvec_base;

    always_comb begin
        mstatus_trap                                  = csr_mstatus_read_data_i;
        mstatus_trap[MSTATUS_MPIE_BIT]                = csr_mstatus_read_data_i[MSTATUS_MIE_BIT];
        mstatus_trap[MSTATUS_MIE_BIT]                 = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = PRIV_LVL_M;

        mstatus_mret                                  = csr_mstatus_read_data_i;
        mstatus_mret[MSTATUS_MIE_BIT]                 = csr_mstatus_read_data_i[MSTATUS_MPIE_BIT];
        mstatus_mret[MSTATUS_MPIE_BIT]                = 1'b1;
        mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = PRIV_LVL_M;
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        target_d = target_q;
        unique case (state_q)
            ST_IDLE: begin
                // A trap beats a simultaneous mret; the mret is dropped.
                if (trap_valid_i) begin
                    cause_d = trap_cause_i;
                    pc_d    = trap_pc_i;
                    state_d = ST_TRAP_WR;
                end else if (mret_valid_i) begin
                    state_d = ST_MRET_WR;
                end
            end
            ST_TRAP_WR: begin
                target_d = trap_target;
                state_d  = ST_REDIRECT;
            end
            ST_MRET_WR: begin
                target_d = {csr_mepc_read_data_i[DW-1:1], 1'b0};
                state_d  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    assign req_ready_o               = in_idle;
    assign busy_o                    = !in_idle;
    assign csr_gen_write_valid_o     = csr_gen_write_valid_i & in_idle;

    assign csr_mstatus_write_valid_o = in_trap_wr | in_mret_wr;
    assign csr_mepc_write_valid_o    = in_trap_wr;
    assign csr_mcause_write_valid_o  = in_trap_wr;

    assign csr_mstatus_write_data_o  = in_trap_wr ? mstatus_trap :
                                       in_mret_wr ? mstatus_mret : '0;
    assign csr_mepc_write_data_o     = in_trap_wr ? {pc_q[DW-1:1], 1'b0} : '0;
    assign csr_mcause_write_data_o   = in_trap_wr ? cause_q : '0;

    assign redirect_valid_o          = in_redirect;
    assign redirect_pc_o             = in_redirect ? target_q : '0;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
module tb_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, mret_valid, req_ready;
    logic [63:0] trap_cause, trap_pc;
    logic [63:0] mstatus_rd, mepc_rd, mtvec_rd;
    logic [63:0] mstatus_wd, mepc_wd, mcause_wd;
    logic        mstatus_wv, mepc_wv, mcause_wv;
    logic        gen_wv_i, gen_wv_o;
    logic        redir_valid, redir_ready, busy;
    logic [63:0] redir_pc;

    always #5 clk = ~clk;

    riscv_trap_ctrl #(.DATA_WIDTH(64)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .trap_valid_i              (trap_valid),
        .trap_cause_i              (trap_cause),
        .trap_pc_i                 (trap_pc),
        .mret_valid_i              (mret_valid),
        .req_ready_o               (req_ready),
        .csr_mstatus_read_data_i   (mstatus_rd),
        .csr_mepc_read_data_i      (mepc_rd),
        .csr_mtvec_read_data_i     (mtvec_rd),
        .csr_mstatus_write_data_o  (mstatus_wd),
        .csr_mepc_write_data_o     (mepc_wd),
        .csr_mcause_write_data_o   (mcause_wd),
        .csr_mstatus_write_valid_o (mstatus_wv),
        .csr_mepc_write_valid_o    (mepc_wv),
        .csr_mcause_write_valid_o  (mcause_wv),
        .csr_gen_write_valid_i     (gen_wv_i),
        .csr_gen_write_valid_o     (gen_wv_o),
        .redirect_valid_o          (redir_valid),
        .redirect_pc_o             (redir_pc),
        .redirect_ready_i          (redir_ready),
        .busy_o                    (busy)
    );

    typedef struct {
        logic [2:0]  strb;   // {mstatus, mepc, mcause}
        logic [63:0] mstatus;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request in IDLE, then check writes at N+1 and redirect
    // from N+2, holding redirect_ready low for 'hold' cycles.
    task automatic run_req(input string tag, input logic t, input logic m,
                           input logic [63:0] cause, input logic [63:0] pc,
                           input logic [63:0] ms, input logic [63:0] ep,
                           input logic [63:0] tv, input exp_t e, input int hold);
        exp_t   got;
        logic [63:0] pc_at_start;
        int     n;
        @(negedge clk);
        trap_valid = t; mret_valid = m; trap_cause = cause; trap_pc = pc;
        mstatus_rd = ms; mepc_rd = ep; mtvec_rd = tv; redir_ready = 1'b0;
        chk({tag, "_ready_idle"}, {63'd0, req_ready}, 64'd1);
        sb.push_back(e);
        @(negedge clk);  // cycle N+1
        trap_valid = 1'b0; mret_valid = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        got = sb.pop_front();
        chk({tag, "_strb"}, {61'd0, mstatus_wv, mepc_wv, mcause_wv}, {61'd0, got.strb});
        chk({tag, "_mstatus"}, mstatus_wd, got.mstatus);
        chk({tag, "_mepc"}, mepc_wd, got.mepc);
        chk({tag, "_mcause"}, mcause_wd, got.mcause);
        chk({tag, "_gen_blk1"}, {63'd0, gen_wv_o}, 64'd0);
        @(negedge clk);  // cycle N+2
        chk({tag, "_rvalid"}, {63'd0, redir_valid}, 64'd1);
        chk({tag, "_rpc"}, redir_pc, got.rpc);
        chk({tag, "_strb_redir"}, {61'd0, mstatus_wv, mepc_wv, mcause_wv}, 64'd0);
        pc_at_start = redir_pc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {63'd0, redir_valid}, 64'd1);
            chk({tag, "_hold_pc"}, redir_pc, pc_at_start);
            chk({tag, "_hold_busy_rdy"}, {62'd0, busy, req_ready}, 64'd2);
            chk({tag, "_gen_blk2"}, {63'd0, gen_wv_o}, 64'd0);
        end
        redir_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_lat"}, n, 0);
        chk({tag, "_idle_state"}, {62'd0, busy, redir_valid}, 64'd0);
        chk({tag, "_gen_pass"}, {63'd0, gen_wv_o}, {63'd0, gen_wv_i});
        redir_ready = 1'b0;
    endtask

    function automatic exp_t mk(input logic [2:0] s, input logic [63:0] ms,
                                input logic [63:0] ep, input logic [63:0] mc,
                                input logic [63:0] rp);
        exp_t e;
        e.strb = s; e.mstatus = ms; e.mepc = ep; e.mcause = mc; e.rpc = rp;
        return e;
    endfunction

    initial begin
        rst = 1'b1;
        trap_valid = 1'b0; mret_valid = 1'b0; trap_cause = '0; trap_pc = '0;
        mstatus_rd = '0; mepc_rd = '0; mtvec_rd = '0; gen_wv_i = 1'b0; redir_ready = 1'b0;
        #1;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy_rvalid", {62'd0, busy, redir_valid}, 64'd0);
        chk("rst_strb", {61'd0, mstatus_wv, mepc_wv, mcause_wv}, 64'd0);
        chk("rst_wdata", mstatus_wd | mepc_wd | mcause_wd | redir_pc, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic direct-mode trap
        run_req("trap_direct", 1, 0, 64'hB, 64'h8000_0004, 64'h8, 64'h0, 64'h8000_1000,
                mk(3'b111, 64'h1880, 64'h8000_0004, 64'hB, 64'h8000_1000), 0);
        // Vectored interrupt
        run_req("trap_vec", 1, 0, 64'h8000_0000_0000_0007, 64'h8000_0010, 64'h8, 64'h0, 64'h8000_1001,
                mk(3'b111, 64'h1880, 64'h8000_0010, 64'h8000_0000_0000_0007, 64'h8000_101C), 0);
        // Vectored mode but exception -> base; odd pc -> LSB cleared; MIE=0 keeps other bits
        run_req("trap_vec_exc", 1, 0, 64'h5, 64'h1001, 64'hFFFF_FFFF_FFFF_FFF7, 64'h0, 64'h2001,
                mk(3'b111, 64'hFFFF_FFFF_FFFF_FF77, 64'h1000, 64'h5, 64'h2000), 0);
        // Reserved mode 2'b11 with interrupt -> base only
        run_req("trap_mode3", 1, 0, 64'h8000_0000_0000_0003, 64'h40, 64'h0, 64'h0, 64'h3003,
                mk(3'b111, 64'h1800, 64'h40, 64'h8000_0000_0000_0003, 64'h3000), 0);
        // Vectored target wraps mod 2^64
        run_req("trap_wrap", 1, 0, 64'h8000_0000_0000_0010, 64'h80, 64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1,
                mk(3'b111, 64'h1880, 64'h80, 64'h8000_0000_0000_0010, 64'h30), 0);
        // mret
        run_req("mret", 0, 1, 64'h0, 64'h0, 64'h1880, 64'h8000_0004, 64'h0,
                mk(3'b100, 64'h1888, 64'h0, 64'h0, 64'h8000_0004), 0);
        // mret with MPIE=0, odd mepc
        run_req("mret_mpie0", 0, 1, 64'h0, 64'h0, 64'h8, 64'h8000_0005, 64'h0,
                mk(3'b100, 64'h1880, 64'h0, 64'h0, 64'h8000_0004), 0);
        // Trap and mret together with a generic write request: trap only
        gen_wv_i = 1'b1;
        @(negedge clk);
        chk("gen_idle_pass", {63'd0, gen_wv_o}, 64'd1);
        run_req("trap_mret", 1, 1, 64'h2, 64'h100, 64'h8, 64'h0, 64'h4000,
                mk(3'b111, 64'h1880, 64'h100, 64'h2, 64'h4000), 0);
        gen_wv_i = 1'b0;
        // Redirect back-pressure for 5 cycles
        run_req("stall", 1, 0, 64'hB, 64'h8000_0004, 64'h8, 64'h0, 64'h8000_1000,
                mk(3'b111, 64'h1880, 64'h8000_0004, 64'hB, 64'h8000_1000), 5);

        // Reset during TRAP_WR
        @(negedge clk);
        trap_valid = 1'b1; trap_cause = 64'hB; trap_pc = 64'h8000_0004;
        mstatus_rd = 64'h8; mtvec_rd = 64'h8000_1000;
        @(negedge clk);
        trap_valid = 1'b0;
        chk("rst_mid_pre_strb", {61'd0, mstatus_wv, mepc_wv, mcause_wv}, 64'd7);
        rst = 1'b1;
        #1;
        chk("rst_mid_strb", {61'd0, mstatus_wv, mepc_wv, mcause_wv}, 64'd0);
        chk("rst_mid_wdata", mstatus_wd | mepc_wd | mcause_wd, 64'd0);
        chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_quiet", {59'd0, mstatus_wv, mepc_wv, mcause_wv, redir_valid, busy}, 64'd0);
            chk("rst_after_ready", {63'd0, req_ready}, 64'd1);
        end
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
